// File: rtl/ram_scan_if.sv
// Bus between the scan reader, its controls, the RAM read port and the display path.
// ram_rden is a one-cycle strobe with no backpressure; ram_q is sampled exactly RD_LAT cycles later.
interface ram_scan_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              load;
    logic              step;
    logic              run;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rden;
    logic [DATA_W-1:0] ram_q;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              busy;
    logic              wrap;

    modport master (
        output load, step, run, start_addr, end_addr, ram_q,
        input  ram_addr, ram_rden, disp_addr, disp_data, disp_valid, busy, wrap
    );

    modport slave (
        input  load, step, run, start_addr, end_addr, ram_q,
        output ram_addr, ram_rden, disp_addr, disp_data, disp_valid, busy, wrap
    );
endinterface

// File: rtl/ram_scan_reader.sv
// Steps a read address through [start_addr..end_addr] of a synchronous RAM and
// latches each completed read into display registers.
module ram_scan_reader #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int TICK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    ram_scan_if.slave  bus,
    output logic [1:0] state_dbg
);
    localparam int TICK_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, HOLD = 2'd3} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cur, cur_nxt;
    logic [1:0]          wait_cnt, wait_nxt;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;
    logic                advance;
    logic                capture;
    logic                rden;
    logic                wrap;
    logic [ADDR_W-1:0]   disp_addr;
    logic [DATA_W-1:0]   disp_data;
    logic                disp_valid;

    assign tick    = bus.run && (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign advance = bus.step || tick;

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        wait_nxt  = wait_cnt;
        capture   = 1'b0;
        rden      = 1'b0;
        wrap      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.load) begin
                    cur_nxt   = bus.start_addr;
                    state_nxt = ISSUE;
                end else if (advance) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                rden = 1'b1;
                if (bus.load) begin
                    cur_nxt   = bus.start_addr;
                    state_nxt = ISSUE;
                end else begin
                    wait_nxt  = 2'(RD_LAT - 1);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // load abandons the outstanding read; its data is never captured
                if (bus.load) begin
                    cur_nxt   = bus.start_addr;
                    state_nxt = ISSUE;
                end else if (wait_cnt == 2'd0) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    wait_nxt = wait_cnt - 2'd1;
                end
            end
            HOLD: begin
                if (bus.load) begin
                    cur_nxt   = bus.start_addr;
                    state_nxt = ISSUE;
                end else if (advance) begin
                    if (cur == bus.end_addr) begin
                        cur_nxt = bus.start_addr;
                        wrap    = 1'b1;
                    end else begin
                        cur_nxt = cur + ADDR_W'(1);
                    end
                    state_nxt = ISSUE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= '0;
            wait_cnt   <= '0;
            tick_cnt   <= '0;
            disp_addr  <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            cur      <= cur_nxt;
            wait_cnt <= wait_nxt;
            if (!bus.run || bus.load || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
            if (capture) begin
                disp_addr  <= cur;
                disp_data  <= bus.ram_q;
                disp_valid <= 1'b1;
            end
        end
    end

    assign bus.ram_addr   = cur;
    assign bus.ram_rden   = rden;
    assign bus.wrap       = wrap;
    assign bus.busy       = (state == ISSUE) || (state == WAIT);
    assign bus.disp_addr  = disp_addr;
    assign bus.disp_data  = disp_data;
    assign bus.disp_valid = disp_valid;
    assign state_dbg      = state;
endmodule
